// File: rtl/id_ex_stage.sv
// Purpose : MIPS ID stage main-control decode, load-use hazard detect and ID/EX pipeline register.
// Latency : one cycle from the ID inputs to the ex_* outputs. stall and id_* are combinational.
// Backpressure: stall holds PC and IF/ID upstream while a bubble is loaded here. flush also forces a bubble.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset.
//   instr_id, pc4_id       instruction in ID and its PC+4.
//   rdata1_id, rdata2_id   register-file reads for rs and rt.
//   flush                  control-hazard flush from the branch/jump logic.
//   stall                  load-use stall back to the PC and IF/ID registers.
//   id_branch/bne/jump     ID-stage decode for the branch/jump unit, gated by stall.
//   ex_*                   registered ID/EX controls, specifiers, immediate and operands.
module id_ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_id,
  input  logic [WIDTH-1:0] pc4_id,
  input  logic [WIDTH-1:0] rdata1_id,
  input  logic [WIDTH-1:0] rdata2_id,
  input  logic             flush,
  output logic             stall,
  output logic             id_branch,
  output logic             id_bne,
  output logic             id_jump,
  output logic             ex_regWrite,
  output logic             ex_memtoReg,
  output logic             ex_memRead,
  output logic             ex_memWrite,
  output logic             ex_aluSrc,
  output logic             ex_regDst,
  output logic [1:0]       ex_aluOp,
  output logic [5:0]       ex_func,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [WIDTH-1:0] ex_imm,
  output logic [WIDTH-1:0] ex_rdata1,
  output logic [WIDTH-1:0] ex_rdata2,
  output logic [WIDTH-1:0] ex_pc4
);

  typedef struct packed {
    logic       reg_write;
    logic       memto_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [5:0]       func;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;
    logic [WIDTH-1:0] pc4;
  } data_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [5:0] opcode;
  logic [4:0] rs_id;
  logic [4:0] rt_id;

  ctrl_t            ctrl_dec;
  logic             branch_dec;
  logic             bne_dec;
  logic             jump_dec;
  logic [WIDTH-1:0] imm_ext;

  ctrl_t ctrl_d, ctrl_q;
  data_t data_d, data_q;

  assign opcode = instr_id[31:26];
  assign rs_id  = instr_id[25:21];
  assign rt_id  = instr_id[20:16];

  // Main control decode. The all-zero word is a nop and must not look like an R-type write of $0.
  always_comb begin
    ctrl_dec   = '0;
    branch_dec = 1'b0;
    bne_dec    = 1'b0;
    jump_dec   = 1'b0;
    if (instr_id != 32'h0) begin
      unique case (opcode)
        OP_RTYPE: begin
          ctrl_dec.reg_dst   = 1'b1;
          ctrl_dec.reg_write = 1'b1;
          ctrl_dec.alu_op    = 2'b10;
        end
        OP_LW: begin
          ctrl_dec.alu_src   = 1'b1;
          ctrl_dec.memto_reg = 1'b1;
          ctrl_dec.reg_write = 1'b1;
          ctrl_dec.mem_read  = 1'b1;
        end
        OP_SW: begin
          ctrl_dec.alu_src   = 1'b1;
          ctrl_dec.mem_write = 1'b1;
        end
        OP_BEQ: begin
          ctrl_dec.alu_op = 2'b01;
          branch_dec      = 1'b1;
        end
        OP_BNE: begin
          ctrl_dec.alu_op = 2'b01;
          branch_dec      = 1'b1;
          bne_dec         = 1'b1;
        end
        OP_ADDI: begin
          ctrl_dec.alu_src   = 1'b1;
          ctrl_dec.reg_write = 1'b1;
        end
        OP_ANDI: begin
          ctrl_dec.alu_src   = 1'b1;
          ctrl_dec.reg_write = 1'b1;
          ctrl_dec.alu_op    = 2'b11;
        end
        OP_J: begin
          jump_dec = 1'b1;
        end
        default: begin
          ctrl_dec = '0;
        end
      endcase
    end
  end

  // andi is a logical op and needs the upper bits clear; everything else uses signed offsets.
  always_comb begin
    if (opcode == OP_ANDI) begin
      imm_ext = {{(WIDTH-16){1'b0}}, instr_id[15:0]};
    end else begin
      imm_ext = {{(WIDTH-16){instr_id[15]}}, instr_id[15:0]};
    end
  end

  // Load-use hazard. rt is compared for every opcode, so some stalls are unnecessary but never missing.
  assign stall = ctrl_q.mem_read && (data_q.rt != 5'd0) &&
                 ((data_q.rt == rs_id) || (data_q.rt == rt_id));

  // The stalled instruction is presented again next cycle, so resolve branches/jumps only once.
  assign id_branch = branch_dec & ~stall;
  assign id_bne    = bne_dec    & ~stall;
  assign id_jump   = jump_dec   & ~stall;

  always_comb begin
    ctrl_d = ctrl_dec;
    if (flush || stall) begin
      ctrl_d = '0;
    end
    data_d.func   = instr_id[5:0];
    data_d.rs     = rs_id;
    data_d.rt     = rt_id;
    data_d.rd     = instr_id[15:11];
    data_d.imm    = imm_ext;
    data_d.rdata1 = rdata1_id;
    data_d.rdata2 = rdata2_id;
    data_d.pc4    = pc4_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign ex_regWrite = ctrl_q.reg_write;
  assign ex_memtoReg = ctrl_q.memto_reg;
  assign ex_memRead  = ctrl_q.mem_read;
  assign ex_memWrite = ctrl_q.mem_write;
  assign ex_aluSrc   = ctrl_q.alu_src;
  assign ex_regDst   = ctrl_q.reg_dst;
  assign ex_aluOp    = ctrl_q.alu_op;
  assign ex_func     = data_q.func;
  assign ex_rs       = data_q.rs;
  assign ex_rt       = data_q.rt;
  assign ex_rd       = data_q.rd;
  assign ex_imm      = data_q.imm;
  assign ex_rdata1   = data_q.rdata1;
  assign ex_rdata2   = data_q.rdata2;
  assign ex_pc4      = data_q.pc4;

endmodule

// File: tb/tb_id_ex_stage.sv
// Purpose : scoreboard bench for id_ex_stage.
// Latency : expected ID/EX contents are queued when ID inputs are driven and popped one edge later.
// Backpressure: stall is predicted from a bench-side model of the EX registers.
module tb_id_ex_stage;

  typedef struct packed {
    logic        reg_write;
    logic        memto_reg;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        reg_dst;
    logic [1:0]  alu_op;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_id = 32'h0;
  logic [31:0] pc4_id = 32'h0;
  logic [31:0] rdata1_id = 32'h0;
  logic [31:0] rdata2_id = 32'h0;
  logic        flush = 1'b0;
  logic        stall, id_branch, id_bne, id_jump;
  logic        ex_regWrite, ex_memtoReg, ex_memRead, ex_memWrite, ex_aluSrc, ex_regDst;
  logic [1:0]  ex_aluOp;
  logic [5:0]  ex_func;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_imm, ex_rdata1, ex_rdata2, ex_pc4;

  exp_t obs;
  exp_t m_ex;
  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .instr_id(instr_id), .pc4_id(pc4_id),
    .rdata1_id(rdata1_id), .rdata2_id(rdata2_id), .flush(flush),
    .stall(stall), .id_branch(id_branch), .id_bne(id_bne), .id_jump(id_jump),
    .ex_regWrite(ex_regWrite), .ex_memtoReg(ex_memtoReg), .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite), .ex_aluSrc(ex_aluSrc), .ex_regDst(ex_regDst),
    .ex_aluOp(ex_aluOp), .ex_func(ex_func), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_pc4(ex_pc4)
  );

  assign obs = {ex_regWrite, ex_memtoReg, ex_memRead, ex_memWrite, ex_aluSrc, ex_regDst,
                ex_aluOp, ex_func, ex_rs, ex_rt, ex_rd, ex_imm, ex_rdata1, ex_rdata2, ex_pc4};

  // Returns {regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, aluOp[1:0]}.
  function automatic logic [7:0] ref_ctrl(input logic [31:0] ins);
    if (ins == 32'h0) return 8'h00;
    case (ins[31:26])
      6'b000000: return 8'b1_0_0_1_0_0_10;
      6'b100011: return 8'b0_1_1_1_1_0_00;
      6'b101011: return 8'b0_1_0_0_0_1_00;
      6'b000100: return 8'b0_0_0_0_0_0_01;
      6'b000101: return 8'b0_0_0_0_0_0_01;
      6'b001000: return 8'b0_1_0_1_0_0_00;
      6'b001100: return 8'b0_1_0_1_0_0_11;
      default:   return 8'h00;
    endcase
  endfunction

  function automatic logic model_stall();
    return m_ex.mem_read && (m_ex.rt != 5'd0) &&
           ((m_ex.rt == instr_id[25:21]) || (m_ex.rt == instr_id[20:16]));
  endfunction

  function automatic exp_t model_next();
    exp_t       n;
    logic [7:0] c;
    c = ref_ctrl(instr_id);
    n.reg_dst   = c[7];
    n.alu_src   = c[6];
    n.memto_reg = c[5];
    n.reg_write = c[4];
    n.mem_read  = c[3];
    n.mem_write = c[2];
    n.alu_op    = c[1:0];
    n.func      = instr_id[5:0];
    n.rs        = instr_id[25:21];
    n.rt        = instr_id[20:16];
    n.rd        = instr_id[15:11];
    n.imm       = (instr_id[31:26] == 6'b001100) ? {16'h0, instr_id[15:0]}
                                                 : {{16{instr_id[15]}}, instr_id[15:0]};
    n.rdata1    = rdata1_id;
    n.rdata2    = rdata2_id;
    n.pc4       = pc4_id;
    if (flush || model_stall()) begin
      n.reg_write = 1'b0; n.memto_reg = 1'b0; n.mem_read = 1'b0;
      n.mem_write = 1'b0; n.alu_src = 1'b0; n.reg_dst = 1'b0; n.alu_op = 2'b00;
    end
    if (reset) n = '0;
    return n;
  endfunction

  task automatic set_in(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                        input logic fl, input logic rst);
    instr_id  = ins;
    rdata1_id = r1;
    rdata2_id = r2;
    pc4_id    = 32'h0040_0000 + {ins[7:0], 2'b00};
    flush     = fl;
    reset     = rst;
    #1;
  endtask

  // Queue the expected ID/EX contents for the current inputs, then take one edge.
  task automatic tick();
    exp_t n;
    n = model_next();
    sb.push_back(n);
    @(posedge clk);
    #1;
    m_ex = n;
  endtask

  task automatic test_reset();
    set_in(32'h8C22_0004, 32'h11, 32'h22, 1'b0, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL reset_sb: queue empty, required entry"); end
      else begin
        e = sb.pop_front();
        if (obs !== e || obs !== '0) begin
          errors++; $display("FAIL reset_regs[%0d]: got %h required %h", i, obs, e);
        end
      end
    end
    set_in(32'h8C22_0004, 32'h11, 32'h22, 1'b0, 1'b0);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", stall); end
  endtask

  task automatic test_rtype();
    set_in(32'h0022_1820, 32'd5, 32'd7, 1'b0, 1'b0);
    tick();
    checks++;
    e = sb.pop_front();
    if (obs !== e) begin errors++; $display("FAIL rtype: got %h required %h", obs, e); end
    checks++;
    if ({ex_regDst, ex_regWrite, ex_aluOp, ex_func, ex_rd, ex_rdata1, ex_rdata2} !==
        {1'b1, 1'b1, 2'b10, 6'b100000, 5'd3, 32'd5, 32'd7}) begin
      errors++; $display("FAIL rtype_fields: got rd=%0d func=%b aluop=%b r1=%0d r2=%0d", ex_rd, ex_func, ex_aluOp, ex_rdata1, ex_rdata2);
    end
  endtask

  task automatic test_load_use();
    set_in(32'h8C22_0004, 32'h100, 32'h0, 1'b0, 1'b0);  // lw $2,4($1)
    tick();
    checks++;
    e = sb.pop_front();
    if (obs !== e) begin errors++; $display("FAIL lu_lw: got %h required %h", obs, e); end
    set_in(32'h0044_1820, 32'h9, 32'h4, 1'b0, 1'b0);    // add $3,$2,$4
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_on: got %b required 1", stall); end
    tick();
    checks++;
    e = sb.pop_front();
    if (obs !== e || ex_regWrite !== 1'b0 || ex_aluOp !== 2'b00) begin
      errors++; $display("FAIL lu_bubble: got %h required %h", obs, e);
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_off: got %b required 0", stall); end
    tick();
    checks++;
    e = sb.pop_front();
    if (obs !== e || ex_regWrite !== 1'b1) begin
      errors++; $display("FAIL lu_add: got %h required %h", obs, e);
    end
  endtask

  task automatic test_load_zero();
    set_in(32'h8C20_0000, 32'h1, 32'h0, 1'b0, 1'b0);    // lw $0,0($1)
    tick();
    e = sb.pop_front();
    set_in(32'h0004_1820, 32'h0, 32'h4, 1'b0, 1'b0);    // add $3,$0,$4
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lz_stall: got %b required 0", stall); end
    tick();
    checks++;
    e = sb.pop_front();
    if (obs !== e) begin errors++; $display("FAIL lz_add: got %h required %h", obs, e); end
  endtask

  task automatic test_imm();
    set_in(32'h3025_8001, 32'h1, 32'h0, 1'b0, 1'b0);    // andi $5,$1,0x8001
    tick();
    checks++;
    e = sb.pop_front();
    if (obs !== e || ex_imm !== 32'h0000_8001 || ex_aluOp !== 2'b11) begin
      errors++; $display("FAIL andi: got imm=%h aluop=%b required imm=00008001 aluop=11", ex_imm, ex_aluOp);
    end
    set_in(32'h2025_8001, 32'h1, 32'h0, 1'b0, 1'b0);    // addi $5,$1,0x8001
    tick();
    checks++;
    e = sb.pop_front();
    if (obs !== e || ex_imm !== 32'hFFFF_8001 || ex_aluOp !== 2'b00) begin
      errors++; $display("FAIL addi: got imm=%h aluop=%b required imm=ffff8001 aluop=00", ex_imm, ex_aluOp);
    end
  endtask

  task automatic test_flush_bubble();
    set_in(32'hAC22_0008, 32'h1, 32'h2, 1'b1, 1'b0);    // sw under flush
    tick();
    checks++;
    e = sb.pop_front();
    if (obs !== e || ex_memWrite !== 1'b0 || ex_aluSrc !== 1'b0) begin
      errors++; $display("FAIL flush_sw: got %h required %h", obs, e);
    end
    set_in(32'hFC22_1234, 32'h3, 32'h4, 1'b0, 1'b0);    // opcode 111111
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL bad_op_stall: got %b required 0", stall); end
    tick();
    checks++;
    e = sb.pop_front();
    if (obs !== e) begin errors++; $display("FAIL bad_op: got %h required %h", obs, e); end
    set_in(32'h0000_0000, 32'h0, 32'h0, 1'b0, 1'b0);    // nop
    tick();
    checks++;
    e = sb.pop_front();
    if (obs !== e || ex_regWrite !== 1'b0 || ex_regDst !== 1'b0) begin
      errors++; $display("FAIL nop: got %h required %h", obs, e);
    end
  endtask

  task automatic test_branch_jump();
    set_in(32'h1022_0003, 32'h0, 32'h0, 1'b0, 1'b0);    // beq
    checks++;
    if ({id_branch, id_bne, id_jump} !== 3'b100) begin errors++; $display("FAIL beq_dec: got %b required 100", {id_branch, id_bne, id_jump}); end
    tick(); e = sb.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL beq_regs: got %h required %h", obs, e); end
    set_in(32'h1422_0003, 32'h0, 32'h0, 1'b0, 1'b0);    // bne
    checks++;
    if ({id_branch, id_bne, id_jump} !== 3'b110) begin errors++; $display("FAIL bne_dec: got %b required 110", {id_branch, id_bne, id_jump}); end
    tick(); e = sb.pop_front();
    set_in(32'h0800_0010, 32'h0, 32'h0, 1'b0, 1'b0);    // j
    checks++;
    if ({id_branch, id_bne, id_jump} !== 3'b001) begin errors++; $display("FAIL j_dec: got %b required 001", {id_branch, id_bne, id_jump}); end
    tick(); e = sb.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL j_regs: got %h required %h", obs, e); end
    set_in(32'h8C22_0004, 32'h0, 32'h0, 1'b0, 1'b0);    // lw $2
    tick(); e = sb.pop_front();
    set_in(32'h1043_0002, 32'h0, 32'h0, 1'b1, 1'b0);    // beq $2,$3 with flush and stall together
    checks++;
    if ({stall, id_branch} !== 2'b10) begin errors++; $display("FAIL stall_gate: got stall,branch=%b required 10", {stall, id_branch}); end
    tick(); e = sb.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL flush_stall: got %h required %h", obs, e); end
    set_in(32'h1043_0002, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if ({stall, id_branch} !== 2'b01) begin errors++; $display("FAIL branch_release: got %b required 01", {stall, id_branch}); end
    tick(); e = sb.pop_front();
  endtask

  task automatic test_reset_mid();
    set_in(32'h8C22_0004, 32'h0, 32'h0, 1'b0, 1'b0);
    tick(); e = sb.pop_front();
    set_in(32'h0044_1820, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checks++;
    e = sb.pop_front();
    if (obs !== e) begin errors++; $display("FAIL reset_mid: got %h required %h", obs, e); end
    set_in(32'h0044_1820, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_mid_stall: got %b required 0", stall); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [9];
    logic [31:0] ins;
    logic [7:0]  c;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
            6'b001000, 6'b001100, 6'b000010, 6'b111111};
    for (int i = 0; i < 60; i++) begin
      ins = {ops[$urandom_range(8)], 5'($urandom_range(3)), 5'($urandom_range(3)),
             16'($urandom)};
      set_in(ins, $urandom, $urandom, ($urandom_range(5) == 0), 1'b0);
      c = ref_ctrl(ins);
      checks++;
      if (stall !== model_stall()) begin
        errors++; $display("FAIL b2b_stall[%0d]: got %b required %b", i, stall, model_stall());
      end
      checks++;
      if (id_branch !== ((ins[31:26] == 6'b000100 || ins[31:26] == 6'b000101) && !model_stall())) begin
        errors++; $display("FAIL b2b_branch[%0d]: got %b", i, id_branch);
      end
      tick();
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL b2b_sb[%0d]: queue empty", i); end
      else begin
        e = sb.pop_front();
        if (obs !== e) begin errors++; $display("FAIL b2b[%0d] ctrl=%b: got %h required %h", i, c, obs, e); end
      end
    end
  endtask

  initial begin
    m_ex = '0;
    test_reset();
    test_rtype();
    test_load_use();
    test_load_zero();
    test_imm();
    test_flush_bubble();
    test_branch_jump();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d entries left, required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
